// File: rtl/mac_sequencer_if.sv
// Handshake bundle between the operand/weight fetch logic, mac_sequencer and the writeback stage.
// The master modport is the environment side; the slave modport is the sequencer.
interface mac_sequencer_if #(
    parameter int LEN_W = 8
);
    logic                    start;
    logic                    start_ready;
    logic [LEN_W-1:0]        len;
    logic [7:0]              bias;
    logic                    abort;
    logic                    op_valid;
    logic                    op_ready;
    logic signed [7:0]       a_in;
    logic signed [7:0]       b_in;
    logic                    result_valid;
    logic                    result_ready;
    logic signed [15:0]      result;
    logic                    busy;

    modport master (
        output start, len, bias, abort, op_valid, a_in, b_in, result_ready,
        input  start_ready, op_ready, result_valid, result, busy
    );

    modport slave (
        input  start, len, bias, abort, op_valid, a_in, b_in, result_ready,
        output start_ready, op_ready, result_valid, result, busy
    );
endinterface

// File: rtl/mac_sequencer.sv
// Control FSM that drives one MAC unit through a dot-product job:
// bias preload, LEN operand transfers, then a held result handshake.
module mac_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic               i_clkext,
    input  logic               i_rstext,
    mac_sequencer_if.slave     bus,
    output logic               o_en_mac,
    output logic               o_rst_mac,
    output logic [7:0]         o_bias_out,
    output logic signed [7:0]  o_a_out,
    output logic signed [7:0]  o_b_out,
    input  logic signed [15:0] i_mac_y
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_BIAS,
        S_ACC,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [7:0]       r_bias;
    logic             w_accept;
    logic             w_transfer;
    logic             w_last;

    assign w_accept   = (r_state == S_IDLE) && bus.start && !bus.abort;
    assign w_transfer = (r_state == S_ACC) && bus.op_valid && !bus.abort;
    // Zero length is excluded so len-1 can never underflow into a false match.
    assign w_last     = (r_len != '0) && (r_cnt == r_len - LEN_W'(1));

    always_ff @(posedge i_clkext or posedge i_rstext) begin
        if (i_rstext) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_BIAS;
                end
            end
            S_BIAS: begin
                if (bus.abort) begin
                    w_next_state = S_IDLE;
                end else if (r_len != '0) begin
                    w_next_state = S_ACC;
                end else begin
                    w_next_state = S_DONE;
                end
            end
            S_ACC: begin
                if (bus.abort) begin
                    w_next_state = S_IDLE;
                end else if (w_transfer && w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.abort || bus.result_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Handshake outputs come from r_state only; EN_MAC alone looks at OP_VALID/ABORT.
    always_comb begin
        bus.start_ready  = 1'b0;
        bus.busy         = 1'b1;
        bus.op_ready     = 1'b0;
        bus.result_valid = 1'b0;
        bus.result       = '0;
        o_en_mac         = 1'b0;
        o_rst_mac        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                bus.start_ready = 1'b1;
                bus.busy        = 1'b0;
            end
            S_BIAS: begin
                o_en_mac  = !bus.abort;
                o_rst_mac = 1'b1;
            end
            S_ACC: begin
                bus.op_ready = 1'b1;
                o_en_mac     = w_transfer;
            end
            S_DONE: begin
                bus.result_valid = 1'b1;
                bus.result       = i_mac_y;
            end
            default: begin
                bus.busy = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clkext or posedge i_rstext) begin
        if (i_rstext) begin
            r_len  <= '0;
            r_bias <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_len  <= bus.len;
            r_bias <= bus.bias;
            r_cnt  <= '0;
        end else if (w_transfer) begin
            r_cnt  <= r_cnt + LEN_W'(1);
        end
    end

    assign o_bias_out = r_bias;
    assign o_a_out    = (r_state == S_ACC) ? bus.a_in : 8'sd0;
    assign o_b_out    = (r_state == S_ACC) ? bus.b_in : 8'sd0;
endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: a behavioural MAC closes the loop, expected
// results come from a saturating dot-product model and are checked by a separate monitor.
module tb_mac_sequencer;
    localparam int LEN_W    = 8;
    localparam int MAX_WAIT = 600;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enMac;
    logic               rstMac;
    logic [7:0]         biasOut;
    logic signed [7:0]  aOut;
    logic signed [7:0]  bOut;
    logic signed [15:0] macY = '0;

    int checkCount = 0;
    int errorCount = 0;
    int expQ[$];
    int jobA[$];
    int jobB[$];
    int patQ[$];
    int enCount = 0;
    bit opReadySeen = 1'b0;
    int lat;
    int acc;
    int lenR;
    int biasR;

    mac_sequencer_if #(.LEN_W(LEN_W)) bus ();

    mac_sequencer #(.LEN_W(LEN_W)) dut (
        .i_clkext   (clk),
        .i_rstext   (rst),
        .bus        (bus),
        .o_en_mac   (enMac),
        .o_rst_mac  (rstMac),
        .o_bias_out (biasOut),
        .o_a_out    (aOut),
        .o_b_out    (bOut),
        .i_mac_y    (macY)
    );

    always #5 clk = ~clk;

    function automatic int clampInt(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Expected result: bias plus the first n products, saturating after every add.
    function automatic int refResult(input int bias, input int n);
        int total = bias;
        for (int i = 0; i < n; i++) total = clampInt(total + jobA[i] * jobB[i]);
        return total;
    endfunction

    function automatic int randOperand();
        case ($urandom_range(7))
            0: return -128;
            1: return 127;
            default: return int'($urandom_range(255)) - 128;
        endcase
    endfunction

    always @(posedge clk) begin
        if (enMac) begin
            if (rstMac) macY <= {8'h00, biasOut};
            else        macY <= 16'(clampInt(int'(macY) + int'(aOut) * int'(bOut)));
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: scoreboard pop on result acceptance plus output gating checks.
    always @(negedge clk) begin
        if (!rst) begin
            if (enMac) enCount++;
            if (bus.op_ready) opReadySeen = 1'b1;
            if (bus.result_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("result_valid_unexpected", int'(bus.result_valid), 0);
                end else begin
                    checkOutput("result", int'(bus.result), expQ[0]);
                    if (bus.result_ready) void'(expQ.pop_front());
                end
            end else begin
                checkOutput("result_zero_when_invalid", int'(bus.result), 0);
            end
            if (bus.op_ready) begin
                checkOutput("a_out_pass", int'(aOut), int'(bus.a_in));
                checkOutput("b_out_pass", int'(bOut), int'(bus.b_in));
            end else begin
                checkOutput("a_out_gated", int'(aOut), 0);
                checkOutput("b_out_gated", int'(bOut), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_start_ready", int'(bus.start_ready), 1);
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_op_ready", int'(bus.op_ready), 0);
        checkOutput("rst_result_valid", int'(bus.result_valid), 0);
        checkOutput("rst_result", int'(bus.result), 0);
        checkOutput("rst_en_mac", int'(enMac), 0);
        checkOutput("rst_rst_mac", int'(rstMac), 0);
        checkOutput("rst_bias_out", int'(biasOut), 0);
        checkOutput("rst_a_out", int'(aOut), 0);
        checkOutput("rst_b_out", int'(bOut), 0);
    endtask

    task automatic startRaw(input int bias, input int len);
        int waitCycles = 0;
        while (!bus.start_ready && waitCycles < MAX_WAIT) begin
            tick();
            waitCycles++;
        end
        checkOutput("start_ready_wait", int'(bus.start_ready), 1);
        bus.len   = LEN_W'(len);
        bus.bias  = 8'(bias);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Runs one job; latency counts cycles from the one in which START is presented.
    task automatic applyStimulus(input int bias, input int len, input int nOffer,
                                 input int validPct, input int stall, input bit midStart,
                                 input int expected, output int latency, output int accepted);
        int  waitCycles;
        int  idx;
        bit  doValid;
        bit  willAccept;
        bit  startPulsed;
        waitCycles = 0;
        while (!bus.start_ready && waitCycles < MAX_WAIT) begin
            tick();
            waitCycles++;
        end
        checkOutput("start_ready_wait", int'(bus.start_ready), 1);
        bus.len     = LEN_W'(len);
        bus.bias    = 8'(bias);
        bus.start   = 1'b1;
        expQ.push_back(expected);
        enCount     = 0;
        opReadySeen = 1'b0;
        tick();
        latency     = 1;
        bus.start   = 1'b0;
        idx         = 0;
        accepted    = 0;
        startPulsed = 1'b0;
        waitCycles  = 0;
        while (!bus.result_valid && bus.busy && waitCycles < MAX_WAIT) begin
            bus.start = 1'b0;
            if (bus.op_ready) begin
                if (patQ.size() > 0) doValid = (patQ.pop_front() != 0);
                else doValid = (idx < nOffer) && (int'($urandom_range(99)) < validPct);
                if (midStart && !startPulsed) begin
                    bus.start   = 1'b1;
                    bus.len     = LEN_W'(1);
                    startPulsed = 1'b1;
                    checkOutput("start_ready_while_busy", int'(bus.start_ready), 0);
                end
            end else begin
                doValid = ($urandom_range(1) == 1);
            end
            if (bus.op_ready && doValid && idx < nOffer) begin
                bus.a_in = 8'(jobA[idx]);
                bus.b_in = 8'(jobB[idx]);
            end else begin
                bus.a_in = 8'(randOperand());
                bus.b_in = 8'(randOperand());
            end
            bus.op_valid = doValid;
            willAccept   = bus.op_ready && doValid;
            tick();
            latency++;
            waitCycles++;
            if (willAccept) begin
                idx++;
                accepted++;
            end
        end
        bus.start    = 1'b0;
        bus.op_valid = 1'b0;
        checkOutput("result_valid_reached", int'(bus.result_valid), 1);
        if (bus.result_valid) begin
            bus.result_ready = 1'b0;
            repeat (stall) tick();
            checkOutput("result_valid_held", int'(bus.result_valid), 1);
            bus.result_ready = 1'b1;
            tick();
            checkOutput("idle_after_result", int'(bus.start_ready), 1);
            checkOutput("busy_after_result", int'(bus.busy), 0);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.start        = 1'b0;
        bus.len          = '0;
        bus.bias         = '0;
        bus.abort        = 1'b0;
        bus.op_valid     = 1'b1;
        bus.a_in         = 8'sd9;
        bus.b_in         = -8'sd3;
        bus.result_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs();
        rst          = 1'b0;
        bus.op_valid = 1'b0;
        tick();

        jobA = '{2, -4, 7};
        jobB = '{3, 5, 7};
        applyStimulus(5, 3, 3, 100, 0, 1'b0, 40, lat, acc);
        checkOutput("t1_latency", lat, 5);
        checkOutput("t1_en_mac_cycles", enCount, 4);

        jobA = '{127, 127, 127};
        jobB = '{127, 127, 127};
        applyStimulus(0, 3, 3, 100, 0, 1'b0, 32767, lat, acc);
        jobA = '{-128, -128, -128};
        applyStimulus(0, 2, 3, 100, 0, 1'b0, -32512, lat, acc);
        checkOutput("t2_accepted", acc, 2);

        jobA.delete();
        jobB.delete();
        applyStimulus(255, 0, 0, 100, 0, 1'b0, 255, lat, acc);
        checkOutput("t3_latency", lat, 2);
        checkOutput("t3_op_ready_seen", int'(opReadySeen), 0);

        jobA = '{1, 1, 1, 1};
        jobB = '{1, 1, 1, 1};
        patQ = '{1, 0, 0, 1, 1, 0, 1};
        applyStimulus(1, 4, 4, 100, 3, 1'b1, 5, lat, acc);
        checkOutput("t4_latency", lat, 9);
        checkOutput("t4_accepted", acc, 4);

        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checkOutput("start_with_abort_ignored", int'(bus.busy), 0);

        startRaw(9, 5);
        tick();
        bus.op_valid = 1'b1;
        bus.a_in     = 8'sd1;
        bus.b_in     = 8'sd1;
        tick();
        bus.abort = 1'b1;
        #1;
        checkOutput("abort_en_mac", int'(enMac), 0);
        checkOutput("abort_in_acc", int'(bus.op_ready), 1);
        tick();
        bus.abort    = 1'b0;
        bus.op_valid = 1'b0;
        checkOutput("abort_to_idle", int'(bus.start_ready), 1);
        checkOutput("abort_not_busy", int'(bus.busy), 0);
        jobA = '{3};
        jobB = '{3};
        applyStimulus(2, 1, 1, 100, 0, 1'b0, 11, lat, acc);

        startRaw(7, 5);
        tick();
        bus.op_valid = 1'b1;
        bus.a_in     = 8'sd2;
        bus.b_in     = 8'sd2;
        tick();
        tick();
        bus.a_in = 8'sd9;
        bus.b_in = -8'sd3;
        rst      = 1'b1;
        #1;
        checkResetOutputs();
        #2;
        rst          = 1'b0;
        bus.op_valid = 1'b0;
        tick();
        jobA = '{2, 4};
        jobB = '{-5, 4};
        applyStimulus(3, 2, 2, 100, 0, 1'b0, 9, lat, acc);

        for (int j = 0; j < 20; j++) begin
            lenR  = int'($urandom_range(10));
            biasR = int'($urandom_range(255));
            jobA.delete();
            jobB.delete();
            for (int i = 0; i < lenR; i++) begin
                jobA.push_back(randOperand());
                jobB.push_back(randOperand());
            end
            applyStimulus(biasR, lenR, lenR, 70, int'($urandom_range(2)), 1'b0,
                          refResult(biasR, lenR), lat, acc);
            checkOutput("rand_accepted", acc, lenR);
        end

        jobA.delete();
        jobB.delete();
        for (int i = 0; i < 255; i++) begin
            jobA.push_back(randOperand());
            jobB.push_back(randOperand());
        end
        applyStimulus(17, 255, 255, 100, 1, 1'b0, refResult(17, 255), lat, acc);
        checkOutput("max_len_accepted", acc, 255);
        checkOutput("max_len_latency", lat, 257);

        tick();
        checkOutput("scoreboard_empty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Control FSM that sequences one MAC unit through a complete dot-product job: it preloads the accumulator with an unsigned 8-bit bias, streams LEN signed operand pairs through the multiplier under a valid/ready handshake, then presents the saturated 16-bit accumulator as a result under a second valid/ready handshake. It sits between the operand/weight fetch logic (upstream) and the activation/writeback stage (downstream), and it is the only block that drives the MAC's EN_MAC, RST_MAC, BIAS_IN, A and B inputs.

## Interface
- LEN_W, 8, width of the job length field; maximum job length is 2^LEN_W − 1 pairs.
- CLKEXT  in  1  clock; all state updates on rising edge.
- RSTEXT  in  1  reset, asynchronous, active-high.
- START  in  1  job request; accepted only when START_READY=1.
- START_READY  out  1  high in IDLE only.
- LEN  in  LEN_W  number of operand pairs, captured with START.
- BIAS  in  8  unsigned bias, captured with START.
- ABORT  in  1  cancels the current job.
- OP_VALID  in  1  operand pair valid.
- OP_READY  out  1  high in ACC only.
- A_IN, B_IN  in  8 each  signed operands.
- RESULT_VALID  out  1  high in DONE only.
- RESULT_READY  in  1  downstream accepts the result.
- RESULT  out  16  signed result; equals MAC_Y in DONE, 0 otherwise.
- BUSY  out  1  high in any state other than IDLE.
- EN_MAC, RST_MAC  out  1 each  MAC enable and bias-load select.
- BIAS_OUT  out  8  to MAC BIAS_IN.
- A_OUT, B_OUT  out  8 each  to MAC A and B.
- MAC_Y  in  16  MAC accumulator output.

## Operation
- States: IDLE, BIAS, ACC, DONE. Registers: state, len_r (LEN_W), bias_r (8), cnt (LEN_W).
- IDLE: START=1 captures LEN into len_r and BIAS into bias_r, clears cnt, then goes to BIAS.
- BIAS: EN_MAC=1 and RST_MAC=1 for exactly one cycle, so the MAC loads {8'h00, bias_r}. Next state is ACC if len_r≠0, else DONE.
- ACC: OP_READY=1. A transfer occurs when OP_VALID=1 while in ACC. On a transfer, EN_MAC=1, RST_MAC=0, and the MAC adds A_IN×B_IN with its own 16-bit saturation. cnt increments on each transfer. A transfer with cnt==len_r−1 moves the FSM to DONE.
- DONE: RESULT_VALID=1 and RESULT=MAC_Y. EN_MAC=0, so MAC_Y holds. RESULT_READY=1 moves the FSM to IDLE.
- Output gating:
  - EN_MAC=0 in every state or cycle not listed above.
  - RST_MAC=1 only in BIAS.
  - A_OUT and B_OUT equal A_IN and B_IN when OP_READY=1, else 0.
  - BIAS_OUT=bias_r at all times.
- ABORT=1 in BIAS, ACC or DONE forces EN_MAC=0 that cycle, and the next state is IDLE. ABORT takes priority over transfer and RESULT_READY. ABORT in IDLE is ignored, and START is not accepted in a cycle where ABORT=1.
- START while not IDLE is ignored; no queueing.
- OP_VALID outside ACC is ignored, with no transfer and no count.

## Timing
- Reset values: state=IDLE, len_r=0, bias_r=0, cnt=0. Resulting outputs: START_READY=1, BUSY=0, OP_READY=0, RESULT_VALID=0, RESULT=0, EN_MAC=0, RST_MAC=0, BIAS_OUT=0, A_OUT=0, B_OUT=0.
- Reset asserted mid-job returns to IDLE immediately. MAC contents are then don't-care; the next job reloads the bias.
- All handshake outputs are decoded from registered state only. They never depend combinationally on START, OP_VALID or RESULT_READY.
- EN_MAC depends combinationally on OP_VALID and ABORT in ACC.
- Latency from START accept (edge 0) to RESULT_VALID with no stalls:
  - LEN=0: 2 cycles, as IDLE→BIAS→DONE.
  - LEN=N: N+2 cycles.
- Throughput: one pair per cycle in ACC. Each OP_VALID=0 cycle adds one cycle.
- Minimum job-to-job spacing is LEN+3 cycles, since DONE→IDLE takes one cycle before the next START is accepted.
- LEN=2^LEN_W−1 must complete without cnt wrap. The compare is cnt==len_r−1, evaluated only when len_r≠0.

## Test plan
- BIAS=5, LEN=3, pairs (2,3),(−4,5),(7,7), continuous OP_VALID → RESULT_VALID 5 cycles after START; RESULT=40; EN_MAC high exactly 4 cycles.
- BIAS=0, LEN=3, pairs (127,127)×3 → RESULT=16'h7FFF. Then BIAS=0, LEN=2, pairs (−128,127)×3 offered → only 2 accepted, RESULT=−32512 (16'h8100).
- BIAS=8'hFF, LEN=0 → RESULT=255 (zero-extended) two cycles after START; OP_READY never asserts.
- BIAS=1, LEN=4, OP_VALID toggling 1,0,0,1,1,0,1 with pairs (1,1) each → RESULT=5. Hold RESULT_READY=0 for 3 cycles → RESULT stable and RESULT_VALID held. START during the job → ignored.
- ABORT in the 2nd ACC cycle of a LEN=5 job → IDLE next cycle, EN_MAC=0 in the ABORT cycle. A new job BIAS=2, LEN=1, pair (3,3) → RESULT=11.
- Assert RSTEXT asynchronously in mid-ACC → all outputs at reset values before the next edge. The following job runs correctly.
